// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the sorter RAM port arbiter: FSM encoding and
// the fixed master slot assignment.
package ram_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int LOADER  = 0;
  localparam int CMPSWAP = 1;
  localparam int READOUT = 2;

endpackage

// File: rtl/ram_port_arbiter_rr_select.sv
// Combinational round-robin pick: the first requester found after last_owner,
// wrapping modulo NUM_REQ.
module rr_select #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  // Walk from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx    = '0;
    winner = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last_owner) + off) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner arbitration for the sorter's dual-port RAM, with optional
// lock across read-modify-write and a bounded hold when others are waiting.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_read_addr_1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_read_addr_2,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_write_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_write_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_read_addr_1,
  output logic [ADDR_WIDTH-1:0]            ram_read_addr_2,
  output logic [ADDR_WIDTH-1:0]            ram_write_addr,
  output logic [DATA_WIDTH-1:0]            ram_write_data,
  input  logic [DATA_WIDTH-1:0]            ram_read_data_1,
  input  logic [DATA_WIDTH-1:0]            ram_read_data_2,
  output logic [DATA_WIDTH-1:0]            rd_data_1,
  output logic [DATA_WIDTH-1:0]            rd_data_2,
  output logic                             hold_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t          state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_next;
  logic [CNT_W-1:0]    hold_cnt_reg, hold_cnt_next;
  logic [IDX_W-1:0]    last_owner_reg, last_owner_next;
  logic [IDX_W-1:0]    owner, sel_last, winner;
  logic [NUM_REQ-1:0]  sel_req;
  logic                sel_any, owner_keeps, forced_release;

  logic [ADDR_WIDTH-1:0] ra1_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] ra2_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] wa_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wd_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign ra1_arr[gi] = req_read_addr_1[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign ra2_arr[gi] = req_read_addr_2[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wa_arr[gi]  = req_write_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd_arr[gi]  = req_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        owner = IDX_W'(i);
      end
    end
  end

  // While owned, the owner is masked out so a handoff only goes to someone
  // else; a lone releasing master drops to IDLE and re-wins from there.
  assign sel_req  = req & ~gnt;
  assign sel_last = (state_reg == OWNED) ? owner : last_owner_reg;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (sel_req),
    .last_owner (sel_last),
    .winner     (winner),
    .any_req    (sel_any)
  );

  assign owner_keeps    = req[owner] & lock[owner];
  assign forced_release = (state_reg == OWNED) & owner_keeps &
                          (hold_cnt_reg == HOLD_LAST) & sel_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      gnt            <= '0;
      hold_cnt_reg   <= '0;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg      <= state_next;
      gnt            <= gnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt;
    hold_cnt_next   = hold_cnt_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          state_next    = OWNED;
          gnt_next      = NUM_REQ'(1) << winner;
          hold_cnt_next = '0;
        end
      end
      OWNED: begin
        if (!owner_keeps || forced_release) begin
          last_owner_next = owner;
          hold_cnt_next   = '0;
          if (sel_any) begin
            gnt_next = NUM_REQ'(1) << winner;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ram_we          = 1'b0;
    ram_read_addr_1 = '0;
    ram_read_addr_2 = '0;
    ram_write_addr  = '0;
    ram_write_data  = '0;
    hold_timeout    = forced_release;
    if (state_reg == OWNED) begin
      ram_we          = req_we[owner] & req[owner];
      ram_read_addr_1 = ra1_arr[owner];
      ram_read_addr_2 = ra2_arr[owner];
      ram_write_addr  = wa_arr[owner];
      ram_write_data  = wd_arr[owner];
    end
  end

  assign rd_data_1 = ram_read_data_1;
  assign rd_data_2 = ram_read_data_2;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a cycle-level
// ownership model and a small behavioural RAM.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int MH = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req, lock, req_we;
  logic [NR*AW-1:0]  ra1_f, ra2_f, wa_f;
  logic [NR*DW-1:0]  wd_f;
  logic [NR-1:0]     gnt;
  logic              ram_we, hold_timeout;
  logic [AW-1:0]     ram_read_addr_1, ram_read_addr_2, ram_write_addr;
  logic [DW-1:0]     ram_write_data, ram_read_data_1, ram_read_data_2;
  logic [DW-1:0]     rd_data_1, rd_data_2;

  ram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .req_we(req_we),
    .req_read_addr_1(ra1_f), .req_read_addr_2(ra2_f),
    .req_write_addr(wa_f), .req_write_data(wd_f),
    .gnt(gnt), .ram_we(ram_we),
    .ram_read_addr_1(ram_read_addr_1), .ram_read_addr_2(ram_read_addr_2),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_data_1(ram_read_data_1), .ram_read_data_2(ram_read_data_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: two async reads, one sync write.
  logic [DW-1:0] mem [4];
  assign ram_read_data_1 = mem[ram_read_addr_1];
  assign ram_read_data_2 = mem[ram_read_addr_2];
  always @(posedge clk) if (ram_we) mem[ram_write_addr] <= ram_write_data;

  int n_tests = 0;
  int n_fail  = 0;

  int            m_owner, m_last, m_hold;
  logic [DW-1:0] exp_mem [4];
  logic [NR-1:0] obs_gnt;
  logic          obs_to;
  logic [DW-1:0] obs_rd1, obs_rd2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int after);
    int k;
    for (int i = 1; i <= NR; i++) begin
      k = (after + i) % NR;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_master(input int k, input logic we, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd);
    req_we[k]          = we;
    ra1_f[k*AW +: AW]  = a1;
    ra2_f[k*AW +: AW]  = a2;
    wa_f[k*AW +: AW]   = wa;
    wd_f[k*DW +: DW]   = wd;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_hold  = 0;
  endtask

  // Entered 1 time unit after a rising edge; checks mid-cycle, then advances
  // the model across the next rising edge.
  task automatic run_cycle();
    int            o, w;
    logic          others, keep, e_to, e_we;
    logic [NR-1:0] e_gnt;
    logic [AW-1:0] e1, e2, ew;
    logic [DW-1:0] ed;
    #4;
    o      = m_owner;
    e_gnt  = (o >= 0) ? NR'(1) << o : '0;
    e1     = (o >= 0) ? ra1_f[o*AW +: AW] : '0;
    e2     = (o >= 0) ? ra2_f[o*AW +: AW] : '0;
    ew     = (o >= 0) ? wa_f[o*AW +: AW]  : '0;
    ed     = (o >= 0) ? wd_f[o*DW +: DW]  : '0;
    e_we   = (o >= 0) ? (req_we[o] & req[o]) : 1'b0;
    others = (o >= 0) ? |(req & ~e_gnt) : 1'b0;
    keep   = (o >= 0) ? (req[o] & lock[o]) : 1'b0;
    e_to   = keep && (m_hold == MH - 1) && others;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_read_addr_1", 32'(ram_read_addr_1), 32'(e1));
    check("ram_read_addr_2", 32'(ram_read_addr_2), 32'(e2));
    check("ram_write_addr", 32'(ram_write_addr), 32'(ew));
    check("ram_write_data", 32'(ram_write_data), 32'(ed));
    check("hold_timeout", 32'(hold_timeout), 32'(e_to));
    check("rd_data_1", 32'(rd_data_1), 32'(exp_mem[e1]));
    check("rd_data_2", 32'(rd_data_2), 32'(exp_mem[e2]));
    obs_gnt = gnt;
    obs_to  = hold_timeout;
    obs_rd1 = rd_data_1;
    obs_rd2 = rd_data_2;
    @(posedge clk);
    if (e_we) exp_mem[ew] = ed;
    if (o < 0) begin
      w = rr_pick(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 0;
      end
    end else if (!keep || e_to) begin
      m_last  = o;
      m_owner = rr_pick(req & ~e_gnt, o);
      m_hold  = 0;
    end else if (m_hold < MH - 1) begin
      m_hold++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; lock = '0; req_we = '0;
    ra1_f = '0; ra2_f = '0; wa_f = '0; wd_f = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NR-1:0] g [12];
    int            cnt, to_cnt, to_cyc;
    logic [DW-1:0] hi_val, lo_val;

    for (int i = 0; i < 4; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    reset_n = 1'b0;
    req = '0; lock = '0; req_we = '0;
    ra1_f = '0; ra2_f = '0; wa_f = '0; wd_f = '0;
    #2;
    check("reset_gnt", 32'(gnt), 32'(0));
    check("reset_ram_we", 32'(ram_we), 32'(0));
    check("reset_hold_timeout", 32'(hold_timeout), 32'(0));
    do_reset();

    // Single unlocked loader writing 0x5A to address 2.
    set_master(LOADER, 1'b1, 2'd0, 2'd0, 2'd2, 8'h5A);
    req = 3'b001; lock = 3'b000;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      g[i] = obs_gnt;
    end
    check("single_gnt_c1", 32'(g[1]), 32'(3'b001));
    check("single_gnt_c2", 32'(g[2]), 32'(3'b000));
    check("single_gnt_c3", 32'(g[3]), 32'(3'b001));
    req = '0;
    run_cycle();
    check("single_mem2", 32'(mem[2]), 32'h5A);

    // All three requesting, unlocked: back-to-back rotation.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      g[i] = obs_gnt;
    end
    check("rr_c1", 32'(g[1]), 32'(3'b001));
    check("rr_c2", 32'(g[2]), 32'(3'b010));
    check("rr_c3", 32'(g[3]), 32'(3'b100));
    check("rr_c4", 32'(g[4]), 32'(3'b001));

    // Locked compare-and-swap master starved-against by read-out.
    do_reset();
    req = 3'b110; lock = 3'b010;
    cnt = 0; to_cnt = 0; to_cyc = -1;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      g[i] = obs_gnt;
      if (obs_gnt == 3'b010) cnt++;
      if (obs_to) begin
        to_cnt++;
        to_cyc = i;
      end
    end
    check("hold_cycles", 32'(cnt), 32'(MH));
    check("hold_timeout_count", 32'(to_cnt), 32'(1));
    check("hold_timeout_cycle", 32'(to_cyc), 32'(MH));
    check("hold_next_owner", 32'(g[9]), 32'(3'b100));

    // Lock with nobody else waiting never times out.
    do_reset();
    req = 3'b010; lock = 3'b010;
    cnt = 0; to_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      run_cycle();
      if (obs_gnt == 3'b010) cnt++;
      if (obs_to) to_cnt++;
    end
    check("lone_lock_cycles", 32'(cnt), 32'(20));
    check("lone_lock_timeouts", 32'(to_cnt), 32'(0));

    // Compare-and-swap read-modify-write on addresses 0/1.
    do_reset();
    set_master(LOADER, 1'b1, 2'd0, 2'd0, 2'd0, 8'h30);
    req = 3'b001;
    run_cycle(); run_cycle();
    set_master(LOADER, 1'b1, 2'd0, 2'd0, 2'd1, 8'h10);
    run_cycle(); run_cycle();
    req = 3'b000;
    set_master(CMPSWAP, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00);
    req = 3'b010; lock = 3'b010;
    run_cycle();
    run_cycle();
    check("cas_gnt", 32'(obs_gnt), 32'(3'b010));
    check("cas_rd1", 32'(obs_rd1), 32'h30);
    check("cas_rd2", 32'(obs_rd2), 32'h10);
    hi_val = obs_rd1;
    lo_val = obs_rd2;
    set_master(CMPSWAP, 1'b1, 2'd0, 2'd1, 2'd0, lo_val);
    run_cycle();
    check("cas_locked_gnt", 32'(obs_gnt), 32'(3'b010));
    set_master(CMPSWAP, 1'b1, 2'd0, 2'd1, 2'd1, hi_val);
    lock = 3'b000;
    run_cycle();
    req = 3'b000;
    run_cycle();
    check("cas_mem0", 32'(mem[0]), 32'h10);
    check("cas_mem1", 32'(mem[1]), 32'h30);

    // Asynchronous reset in the middle of a lock.
    do_reset();
    set_master(CMPSWAP, 1'b1, 2'd2, 2'd3, 2'd3, 8'hC3);
    req = 3'b010; lock = 3'b010;
    run_cycle(); run_cycle(); run_cycle();
    #4 reset_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'(0));
    check("async_rst_ram_we", 32'(ram_we), 32'(0));
    check("async_rst_hold_timeout", 32'(hold_timeout), 32'(0));
    model_reset();
    req = 3'b011; lock = 3'b000;
    set_master(LOADER, 1'b0, 2'd1, 2'd2, 2'd0, 8'h00);
    set_master(CMPSWAP, 1'b0, 2'd3, 2'd0, 2'd0, 8'h00);
    @(posedge clk); @(posedge clk);
    #3 reset_n = 1'b1;
    run_cycle();
    run_cycle();
    check("post_rst_first", 32'(obs_gnt), 32'(3'b001));
    run_cycle();
    check("post_rst_second", 32'(obs_gnt), 32'(3'b010));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) begin
        req[k]  = ($urandom_range(0, 9) < 7);
        lock[k] = ($urandom_range(0, 3) != 0);
        set_master(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)));
      end
      run_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      check("rand_mem", 32'(mem[i]), 32'(exp_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
